// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 keyboard frame receiver and make/break key tracker
module ps2_key_tracker #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_down,
    output logic [7:0] key_count,
    output logic       new_key,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BRK  = 1'b1
    } state_t;

    // clk_sync[2] is the synchronised pin; clk_sync[3] is its previous value for edge detect
    logic [3:0]    clk_sync;
    logic [2:0]    data_sync;
    logic          strobe;
    logic          data_s;

    logic [9:0]    shift;
    logic [10:0]   frame;
    logic          frame_ok;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          byte_valid;
    logic [7:0]    rx_byte;

    state_t        state_q, state_d;
    logic          do_press;
    logic          do_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[2:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign strobe = clk_sync[3] & ~clk_sync[2];
    assign data_s = data_sync[2];

    // frame[0]=start, frame[8:1]=data LSB first, frame[9]=parity, frame[10]=stop
    assign frame    = {data_s, shift};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (strobe) begin
                shift  <= {data_s, shift[9:1]};
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= frame[8:1];
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // a stalled partial frame is dropped silently
                if (to_cnt == TW'(TIMEOUT_CYC)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt  <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_valid && rx_byte != 8'hE0) begin
            case (state_q)
                IDLE:    if (rx_byte == 8'hF0) state_d = BRK;
                BRK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // extended-code prefix E0 is transparent; a held key re-sent is typematic repeat
    always_comb begin
        do_press   = 1'b0;
        do_release = 1'b0;
        if (byte_valid && rx_byte != 8'hE0) begin
            if (state_q == IDLE && rx_byte != 8'hF0 &&
                !(key_down && rx_byte == key_code))
                do_press = 1'b1;
            if (state_q == BRK && rx_byte == key_code)
                do_release = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_down  <= 1'b0;
            key_count <= '0;
            new_key   <= 1'b0;
        end else begin
            new_key <= do_press;
            if (do_press) begin
                key_code  <= rx_byte;
                key_down  <= 1'b1;
                key_count <= key_count + 8'd1;
            end else if (do_release) begin
                key_down  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

    localparam int TO   = 100;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_down;
    logic [7:0] key_count;
    logic       new_key;
    logic       frame_err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int fall_cyc = 0;
    int nk_cnt = 0, nk_cyc = -1;
    int fe_cnt = 0, fe_cyc = -1;
    int nk0, fe0;

    ps2_key_tracker #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_down  (key_down),
        .key_count (key_count),
        .new_key   (new_key),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (new_key)   begin nk_cnt++; nk_cyc = cyc; end
            if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        end
    end

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF - 1) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int gap);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11, gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (key_code !== 8'h00) $display("FAIL reset_key_code got %h expected 00", key_code); else passed++;
        total++; if (key_down !== 1'b0) $display("FAIL reset_key_down got %b expected 0", key_down); else passed++;
        total++; if (key_count !== 8'h00) $display("FAIL reset_key_count got %h expected 00", key_count); else passed++;
        total++; if (new_key !== 1'b0) $display("FAIL reset_new_key got %b expected 0", new_key); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b expected 0", frame_err); else passed++;
    endtask

    task automatic test_press();
        nk0 = nk_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        total++; if (key_code !== 8'h1C) $display("FAIL press_key_code got %h expected 1c", key_code); else passed++;
        total++; if (key_down !== 1'b1) $display("FAIL press_key_down got %b expected 1", key_down); else passed++;
        total++; if (key_count !== 8'd1) $display("FAIL press_key_count got %0d expected 1", key_count); else passed++;
        total++; if (nk_cnt - nk0 !== 1) $display("FAIL press_new_key_pulses got %0d expected 1", nk_cnt - nk0); else passed++;
        total++; if (nk_cyc !== fall_cyc + 5) $display("FAIL press_new_key_cycle got %0d expected %0d", nk_cyc, fall_cyc + 5); else passed++;
        total++; if (fe_cnt - fe0 !== 0) $display("FAIL press_frame_err got %0d expected 0", fe_cnt - fe0); else passed++;
    endtask

    task automatic test_typematic();
        nk0 = nk_cnt;
        repeat (3) send_frame(8'h1C, 1'b0, 1'b1, 4);
        total++; if (key_down !== 1'b1) $display("FAIL repeat_key_down got %b expected 1", key_down); else passed++;
        send_frame(8'hF0, 1'b0, 1'b1, 4);
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        total++; if (key_count !== 8'd1) $display("FAIL repeat_key_count got %0d expected 1", key_count); else passed++;
        total++; if (nk_cnt - nk0 !== 0) $display("FAIL repeat_new_key_pulses got %0d expected 0", nk_cnt - nk0); else passed++;
        total++; if (key_down !== 1'b0) $display("FAIL repeat_release_key_down got %b expected 0", key_down); else passed++;
        total++; if (key_code !== 8'h1C) $display("FAIL repeat_key_code got %h expected 1c", key_code); else passed++;
    endtask

    task automatic test_overlap();
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        send_frame(8'h32, 1'b0, 1'b1, 4);
        send_frame(8'hF0, 1'b0, 1'b1, 4);
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        total++; if (key_code !== 8'h32) $display("FAIL overlap_key_code got %h expected 32", key_code); else passed++;
        total++; if (key_down !== 1'b1) $display("FAIL overlap_key_down got %b expected 1", key_down); else passed++;
        total++; if (key_count !== 8'd2) $display("FAIL overlap_key_count got %0d expected 2", key_count); else passed++;
        send_frame(8'hF0, 1'b0, 1'b1, 4);
        send_frame(8'h32, 1'b0, 1'b1, 10);
        total++; if (key_down !== 1'b0) $display("FAIL overlap_release_key_down got %b expected 0", key_down); else passed++;
    endtask

    task automatic test_bad_frames();
        nk0 = nk_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 10);
        total++; if (fe_cnt - fe0 !== 1) $display("FAIL parity_err_pulses got %0d expected 1", fe_cnt - fe0); else passed++;
        total++; if (fe_cyc !== fall_cyc + 4) $display("FAIL parity_err_cycle got %0d expected %0d", fe_cyc, fall_cyc + 4); else passed++;
        total++; if (key_code !== 8'h32) $display("FAIL parity_key_code got %h expected 32", key_code); else passed++;
        send_frame(8'h1C, 1'b0, 1'b0, 10);
        total++; if (fe_cnt - fe0 !== 2) $display("FAIL stop_err_pulses got %0d expected 2", fe_cnt - fe0); else passed++;
        total++; if (fe_cyc !== fall_cyc + 4) $display("FAIL stop_err_cycle got %0d expected %0d", fe_cyc, fall_cyc + 4); else passed++;
        total++; if (key_count !== 8'd2) $display("FAIL bad_key_count got %0d expected 2", key_count); else passed++;
        total++; if (nk_cnt - nk0 !== 0) $display("FAIL bad_new_key_pulses got %0d expected 0", nk_cnt - nk0); else passed++;
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        total++; if (key_count !== 8'd3) $display("FAIL recover_key_count got %0d expected 3", key_count); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        fe0 = fe_cnt;
        send_bits({1'b1, ~^8'h32, 8'h32, 1'b0}, 5, TO + 30);
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        total++; if (key_code !== 8'h1C) $display("FAIL timeout_key_code got %h expected 1c", key_code); else passed++;
        total++; if (key_count !== 8'd1) $display("FAIL timeout_key_count got %0d expected 1", key_count); else passed++;
        total++; if (fe_cnt - fe0 !== 0) $display("FAIL timeout_frame_err got %0d expected 0", fe_cnt - fe0); else passed++;
    endtask

    task automatic test_reset_mid();
        send_bits({1'b1, ~^8'h32, 8'h32, 1'b0}, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (key_code !== 8'h00) $display("FAIL midrst_key_code got %h expected 00", key_code); else passed++;
        total++; if (key_down !== 1'b0) $display("FAIL midrst_key_down got %b expected 0", key_down); else passed++;
        total++; if (key_count !== 8'h00) $display("FAIL midrst_key_count got %h expected 00", key_count); else passed++;
        @(negedge clk);
        rst = 1'b0;
        fe0 = fe_cnt;
        send_frame(8'h66, 1'b0, 1'b1, 10);
        total++; if (key_code !== 8'h66) $display("FAIL postrst_key_code got %h expected 66", key_code); else passed++;
        total++; if (key_count !== 8'd1) $display("FAIL postrst_key_count got %0d expected 1", key_count); else passed++;
        total++; if (fe_cnt - fe0 !== 0) $display("FAIL postrst_frame_err got %0d expected 0", fe_cnt - fe0); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        nk0 = nk_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h32, 1'b0, 1'b1, 10);
        total++; if (key_code !== 8'h32) $display("FAIL b2b_key_code got %h expected 32", key_code); else passed++;
        total++; if (key_count !== 8'd2) $display("FAIL b2b_key_count got %0d expected 2", key_count); else passed++;
        total++; if (nk_cnt - nk0 !== 2) $display("FAIL b2b_new_key_pulses got %0d expected 2", nk_cnt - nk0); else passed++;
        total++; if (fe_cnt - fe0 !== 0) $display("FAIL b2b_frame_err got %0d expected 0", fe_cnt - fe0); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        nk0 = nk_cnt;
        for (int i = 0; i < 256; i++) begin
            send_frame((i % 2) ? 8'h32 : 8'h1C, 1'b0, 1'b1, 2);
            if (i == 254) begin
                total++; if (key_count !== 8'd255) $display("FAIL wrap_count_255 got %0d expected 255", key_count); else passed++;
            end
        end
        repeat (4) @(negedge clk);
        total++; if (key_count !== 8'h00) $display("FAIL wrap_key_count got %h expected 00", key_count); else passed++;
        total++; if (nk_cnt - nk0 !== 256) $display("FAIL wrap_new_key_pulses got %0d expected 256", nk_cnt - nk0); else passed++;
        total++; if (key_code !== 8'h32) $display("FAIL wrap_key_code got %h expected 32", key_code); else passed++;
        total++; if (key_down !== 1'b1) $display("FAIL wrap_key_down got %b expected 1", key_down); else passed++;
    endtask

    initial begin
        test_reset();
        test_press();
        test_typematic();
        test_overlap();
        test_bad_frames();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

- Receives raw PS/2 keyboard frames from the `ps2_clk`/`ps2_data` pins.
- Validates each frame and decodes the make/break scan-code stream.
- Presents the most recent key, its held state and a press counter to the downstream 7-segment display driver (`seg`) and LEDs.
- Sits directly between the board PS/2 pins and the display stage in `top`.

## Interface
- TIMEOUT_CYC, 50000: `clk` cycles with no `ps2_clk` falling edge after which a partial frame is discarded (1 ms at 50 MHz).
- clk  input  1  system clock; all state is in this domain.
- rst  input  1  reset; one clock, asynchronous and active-high, clears all state.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to `clk`.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to `clk`.
- key_code  output  8  scan code of the last pressed key.
- key_down  output  1  high while the key in `key_code` is held.
- key_count  output  8  number of distinct presses, modulo 256.
- new_key  output  1  one-cycle pulse when `key_code`/`key_count` update on a new press.
- frame_err  output  1  one-cycle pulse when a frame is rejected for start, stop or parity error.

## Operation
- Synchronisation:
  - `ps2_clk` and `ps2_data` each pass through a 3-FF synchroniser.
  - A falling-edge strobe is generated when synced `ps2_clk` is 1 in the previous cycle and 0 in the current cycle.
- Frame receiver:
  - On each strobe, sample synced `ps2_data` into an 11-bit shift register and increment bit counter 0..10.
  - Bit order: start(0), d0..d7 (LSB first), parity, stop(1).
  - On the 11th strobe, the frame is valid iff start==0, stop==1 and XOR(d0..d7, parity)==1 (odd parity).
  - A valid frame emits an internal byte_valid with the byte; an invalid frame pulses `frame_err` and discards the byte.
  - The bit counter returns to 0 after the 11th strobe in both cases.
- Timeout:
  - A counter of width $clog2(TIMEOUT_CYC+1) runs while the bit counter is nonzero and clears on every strobe.
  - When it reaches TIMEOUT_CYC, the bit counter resets to 0 with no `frame_err` and no byte.
- Decoder FSM, states IDLE and BREAK:
  - Byte 0xE0, any state: ignored; state unchanged.
  - IDLE, byte 0xF0: go to BREAK.
  - IDLE, other byte b with key_down==1 and b==key_code: typematic repeat; ignored, no `new_key`.
  - IDLE, other byte b otherwise: key_code<=b, key_down<=1, key_count<=key_count+1 (wraps 255->0), `new_key` pulses.
  - BREAK, byte b: if b==key_code then key_down<=0; `key_code` is kept in all cases; go to IDLE.
  - A break for a key other than `key_code` leaves key_down unchanged.
- Reset values:
  - All outputs are 0 (key_code=0x00, key_down=0, key_count=0, new_key=0, frame_err=0).
  - FSM=IDLE, bit counter=0, timeout counter=0, all synchroniser FFs=1 (PS/2 idle level).

## Timing
- Edge strobe is high 3 cycles after `ps2_clk` falls at the pin, for a fall meeting setup to `clk`.
- Let cycle T be the cycle in which the strobe for bit 11 is high.
  - `frame_err` or internal byte_valid is high in cycle T+1, for exactly one cycle.
  - Decoder outputs hold their new values from cycle T+2; `new_key` is high only in cycle T+2.
- Back-to-back frames need no gap; the receiver accepts the next start bit on the strobe immediately following bit 11.
- Reset asserted mid-frame clears the partial frame immediately. The first frame accepted after reset is the first one whose start bit strobes after `rst` deasserts.
- The timeout check and a strobe in the same cycle: the strobe wins and the counter clears.
- Outputs are all registered; no combinational path from pins to outputs.

## Test plan
- Press 'A': frame 0x1C (data 0,0,1,1,1,0,0,0, parity 0) -> key_code=0x1C, key_down=1, key_count=1, one `new_key` pulse at T+2.
- Typematic repeat: three more 0x1C frames, then F0 1C -> key_count stays 1, no further `new_key`, key_down=0 after the 1C, key_code=0x1C.
- Overlapped keys: make 0x1C, make 0x32, F0 1C -> key_code=0x32, key_down=1, key_count=2.
- Then F0 32 -> key_down=0.
- Bad frames:
  - 0x1C with parity=1 -> `frame_err` pulse at T+1, outputs unchanged.
  - stop=0 -> same response.
- Timeout and reset:
  - 5 bits, then idle > TIMEOUT_CYC, then full 0x1C frame -> 0x1C decoded correctly, no `frame_err`.
  - Assert rst mid-frame -> all outputs 0 immediately.
- Counter wrap: 256 alternating makes 0x1C/0x32 from reset -> key_count=0x00 after the 256th press, `new_key` pulsed 256 times.
